// File: rtl/clint_pkg.sv
// Purpose : shared register offsets, reset constants and byte-lane helper for the clint block.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package clint_pkg;

    // Byte offsets within the 64 KiB clint window.
    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    // Compare starts at the maximum so the timer interrupt cannot fire out of reset.
    localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace the byte lanes of old_val selected by sel with the matching lanes of new_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// Purpose : 64-bit mtime counter with tick generation and byte-masked half-word write override.
// Latency : a write or tick is visible on mtime_o the cycle after the edge that applies it.
// Backpressure: none; writes are accepted every cycle they are presented.
//
// Ports: clk_i/rst_i (sync, active-high); wr_lo_i/wr_hi_i select the half being written;
//        wdata_i/sel_i carry the bus data and byte enables; mtime_o is the registered counter.
// Build option: CLINT_PRESCALE_EN enables a divide-by-PRESCALE tick; otherwise it ticks every cycle.
module clint_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  sel_i,
    output logic [63:0] mtime_o
);
    import clint_pkg::*;

    logic        tick;
    logic [63:0] mtime_q, mtime_d;

`ifdef CLINT_PRESCALE_EN
    // A divider of 1 still needs a one-bit counter so the widths stay legal.
    localparam int             CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = cnt_q + CNT_W'(1);
        // Restart the tick period whenever software rewrites mtime.
        if (tick || wr_lo_i || wr_hi_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        mtime_d = mtime_q;
        if (wr_lo_i) begin
            mtime_d[31:0] = merge_bytes(mtime_q[31:0], wdata_i, sel_i);
        end
        if (wr_hi_i) begin
            mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata_i, sel_i);
        end
        // A write owns the cycle: the untouched half holds and no increment happens.
        if (!wr_lo_i && !wr_hi_i && tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q <= '0;
        end else begin
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/clint.sv
// Purpose : core-local interruptor (mtime, mtimecmp, msip) behind a Wishbone-classic slave.
// Latency : ack/err one cycle after the request; interrupt outputs lag their sources by one cycle.
// Backpressure: none; one request per two cycles, a new request is ignored while ack/err is high.
//
// Ports: clk_i/rst_i (sync, active-high); wbs_* is the 32-bit Wishbone slave (addr decoded on [15:0]);
//        int_mtip_o / int_msip_o feed the csr block's timer and software interrupt inputs.
// Build option: CLINT_PRESCALE_EN makes mtime tick once every PRESCALE cycles.
module clint #(
    parameter int ADDR_W   = 16,
    parameter int PRESCALE = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [ADDR_W-1:0] wbs_addr_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [3:0]        wbs_sel_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic              int_mtip_o,
    output logic              int_msip_o
);
    import clint_pkg::*;

    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        int_mtip_q, int_mtip_d;
    logic        int_msip_q, int_msip_d;

    logic [15:0] offset;
    logic        req, wr_req, rd_req;
    logic        hit_msip, hit_cmp_lo, hit_cmp_hi, hit_mtime_lo, hit_mtime_hi, mapped;
    logic [63:0] mtime;

    // The response cycle blocks a new request, so a held strobe cannot double-complete.
    assign req    = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
    assign wr_req = req & wbs_we_i;
    assign rd_req = req & ~wbs_we_i;
    assign offset = wbs_addr_i[15:0];

    assign hit_msip     = (offset == CLINT_MSIP);
    assign hit_cmp_lo   = (offset == CLINT_MTIMECMP_LO);
    assign hit_cmp_hi   = (offset == CLINT_MTIMECMP_HI);
    assign hit_mtime_lo = (offset == CLINT_MTIME_LO);
    assign hit_mtime_hi = (offset == CLINT_MTIME_HI);
    assign mapped       = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_mtime_lo | hit_mtime_hi;

    clint_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_lo_i (wr_req & hit_mtime_lo),
        .wr_hi_i (wr_req & hit_mtime_hi),
        .wdata_i (wbs_dat_i),
        .sel_i   (wbs_sel_i),
        .mtime_o (mtime)
    );

    always_comb begin
        ack_d      = req & mapped;
        err_d      = req & ~mapped;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        dat_d      = '0;

        if (wr_req && hit_cmp_lo) begin
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wbs_dat_i, wbs_sel_i);
        end
        if (wr_req && hit_cmp_hi) begin
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wbs_dat_i, wbs_sel_i);
        end
        // MSIP has a single implemented bit, owned by byte lane 0.
        if (wr_req && hit_msip && wbs_sel_i[0]) begin
            msip_d = wbs_dat_i[0];
        end

        // Read data is captured at the request edge; unmapped offsets read as zero.
        if (rd_req) begin
            if (hit_msip) begin
                dat_d = {31'd0, msip_q};
            end else if (hit_cmp_lo) begin
                dat_d = mtimecmp_q[31:0];
            end else if (hit_cmp_hi) begin
                dat_d = mtimecmp_q[63:32];
            end else if (hit_mtime_lo) begin
                dat_d = mtime[31:0];
            end else if (hit_mtime_hi) begin
                dat_d = mtime[63:32];
            end
        end

        int_mtip_d = (mtime >= mtimecmp_q);
        int_msip_d = msip_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            mtimecmp_q <= CLINT_MTIMECMP_RST;
            msip_q     <= 1'b0;
            int_mtip_q <= 1'b0;
            int_msip_q <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            int_mtip_q <= int_mtip_d;
            int_msip_q <= int_msip_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_err_o  = err_q;
    assign wbs_dat_o  = dat_q;
    assign int_mtip_o = int_mtip_q;
    assign int_msip_o = int_msip_q;

endmodule
